pc_fetch_stage: RTL

- Program-counter register and instruction-fetch sequencer for the RV32 core.
- Holds the current PC, issues one instruction-memory request at a time, and captures the returned word.
- Presents {pc, instr} to the IF/ID boundary with a valid/ready handshake.
- Advances the PC by +4 on each consumed fetch; a branch/jump redirect from EX overrides the PC and flushes the in-flight fetch.

---
 rtl/pc_fetch_stage_if.sv | 30 +++
 rtl/pc_fetch_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage_if.sv
// Bundle of the fetch stage's handshake and bus signals: the instruction-memory
// request/response channel, the EX redirect input, the IF/ID output, and the
// misalignment flag. The master side is the fetch stage; the slave side is its
// environment.
interface pc_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            err_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, err_misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, err_misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Program counter and single-outstanding instruction-fetch sequencer.
// One request at a time: FETCH issues, WAIT collects the word, OUT presents
// {pc, instr} to decode. A redirect from EX replaces the PC and poisons any
// in-flight fetch through the kill flag so its response is discarded.
module pc_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  pc_fetch_stage_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            req_valid_q, req_valid_d;
  logic            if_valid_q, if_valid_d;
  logic            err_q, err_d;

  // Next-state, PC and capture logic; redirect overrides every normal transition.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    err_d      = 1'b0;

    if (bus.redirect_valid) begin
      pc_d  = {bus.redirect_pc[XLEN-1:2], 2'b00};
      err_d = |bus.redirect_pc[1:0];
      unique case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: begin
          // An accepted request is already in flight; its response must be dropped.
          if (bus.imem_req_ready) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_OUT:   state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: begin
          if (bus.imem_req_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_FETCH;
            end else begin
              if_instr_d = bus.imem_rsp_data;
              if_pc_d    = pc_q;
              state_d    = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.if_ready) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Handshake outputs are decoded from the next state so they leave a flop.
    req_valid_d = (state_d == S_FETCH);
    if_valid_d  = (state_d == S_OUT);
  end

  // State and output registers; reset clears everything and abandons any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.err_misaligned = err_q;

endmodule
